uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set the clock cycles per serial bit (legal range 2..65535).
REQ-002 Parameter STOP_BITS, default 1, SHALL set the number of stop bits (legal values 1 or 2).
REQ-003 clock  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 tx_data  input  8  SHALL carry the byte to send; it is sampled only at accept.
REQ-006 tx_ready  input  1  SHALL request a frame; a rising edge requests a new byte.
REQ-007 tx_done  output  1  SHALL be high when idle or when the last frame is complete, and low while a frame is in progress.
REQ-008 tx  output  1  SHALL be the serial line, idle high.

Function
REQ-009 Block SHALL register tx_ready into tx_ready_last every cycle; accept = tx_ready && !tx_ready_last && state==IDLE.
REQ-010 State machine SHALL have states IDLE, START, DATA, PARITY (only with macro), STOP; any other encoding SHALL return to IDLE on the next cycle.
REQ-011 On the accept edge, the block SHALL load tx_data into the shift register, clear the baud and bit counters, drive tx<=0 and tx_done<=0, and enter START.
REQ-012 tx SHALL change exactly one cycle after the accept edge (registered output); there is no combinational path from inputs to outputs.
REQ-013 The baud counter SHALL count 0..CLKS_PER_BIT-1; each bit period is exactly CLKS_PER_BIT cycles.
REQ-014 START SHALL hold tx=0 for one bit period, then enter DATA.
REQ-015 DATA SHALL send bits 0..7 LSB first, one per bit period, using a 3-bit counter; after bit 7 it SHALL enter PARITY (macro on) or STOP.
REQ-016 STOP SHALL hold tx=1 for STOP_BITS bit periods, then set tx_done<=1 and enter IDLE.
REQ-017 Frame length from accept to tx_done rising SHALL be (1+8+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with the macro and P=0 without.
REQ-018 Rising edges of tx_ready outside IDLE SHALL be ignored, not queued; tx_data changes after accept SHALL NOT affect the frame.
REQ-019 tx_ready held high after tx_done rises SHALL NOT start a new frame; only a low-then-high transition does.
REQ-020 A tx_ready edge on the same cycle tx_done rises SHALL be ignored (state is still STOP); the requester SHALL drop and re-raise tx_ready.
REQ-021 With the upstream string sequencer (tx_ready low for one cycle between bytes), the next frame SHALL start with tx held high between frames.

Reset
REQ-022 While reset is high: state=IDLE, tx=1, tx_done=1, tx_ready_last=1, counters=0, shift register=0.
REQ-023 tx_ready_last resets to 1, so a tx_ready already high at reset release SHALL NOT start a frame.
REQ-024 Reset asserted mid-frame SHALL abort the frame; tx returns to 1 and tx_done to 1 on the next edge, with no partial stop bit.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: the PARITY state SHALL send one even-parity bit (XOR of the 8 data bits) for one bit period between DATA and STOP.
REQ-026 Macro UART_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification (CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-027 Reset then idle 20 cycles -> tx=1 and tx_done=1 throughout; no frame starts even with tx_ready held high from reset.
REQ-028 Pulse tx_ready with tx_data=0x55, no macro -> tx holds 0,1,0,1,0,1,0,1,0,1 for 4 cycles each; tx_done low 40 cycles, then high.
REQ-029 UART_TX_PARITY_EN with 0x07 -> parity bit 1 and frame 44 cycles; with 0x55 -> parity bit 0.
REQ-030 Change tx_data to 0xFF and pulse tx_ready again mid-frame of 0x3C -> 0x3C is sent intact and the second request is ignored.
REQ-031 Assert reset during bit 3 of 0xA5 -> tx=1 and tx_done=1 one cycle later; a new request after release sends a full, correct frame.
REQ-032 Drive a "HI" string via the upstream handshake, STOP_BITS=2 -> frames 0x48 then 0x49 are each 44 cycles, with tx high between them.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert one even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       tx_done,
  output logic       tx
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  state_t      state, state_next;
  logic [15:0] baud_cnt, baud_next;
  logic [2:0]  bit_cnt, bit_next;
  logic        stop_cnt, stop_next;
  logic [7:0]  shift_reg, shift_next;
  logic        tx_next, done_next;
  logic        tx_ready_last;
  logic        baud_tick;
  logic        accept;
`ifdef UART_TX_PARITY_EN
  logic        parity_bit, parity_next;
`endif

  assign baud_tick = (baud_cnt == BAUD_LAST);
  // Only a low-to-high transition while idle starts a frame; edges mid-frame are dropped.
  assign accept    = tx_ready && !tx_ready_last && (state == IDLE);

  // NOTE: every output of this block is given a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    stop_next  = stop_cnt;
    shift_next = shift_reg;
    tx_next    = tx;
    done_next  = tx_done;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_bit;
`endif

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (accept) begin
          shift_next = tx_data;
          baud_next  = '0;
          bit_next   = '0;
          stop_next  = 1'b0;
          tx_next    = 1'b0;
          done_next  = 1'b0;
          state_next = START;
`ifdef UART_TX_PARITY_EN
          parity_next = ^tx_data;
`endif
        end
      end

      START: begin
        if (baud_tick) begin
          baud_next  = '0;
          tx_next    = shift_reg[0];
          shift_next = {1'b0, shift_reg[7:1]};
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end

      DATA: begin
        if (baud_tick) begin
          baud_next = '0;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_next    = parity_bit;
            state_next = PARITY;
`else
            tx_next    = 1'b1;
            stop_next  = 1'b0;
            state_next = STOP;
`endif
          end else begin
            bit_next   = bit_cnt + 3'd1;
            tx_next    = shift_reg[0];
            shift_next = {1'b0, shift_reg[7:1]};
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          baud_next  = '0;
          tx_next    = 1'b1;
          stop_next  = 1'b0;
          state_next = STOP;
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
`endif

      STOP: begin
        if (baud_tick) begin
          baud_next = '0;
          if (stop_cnt == STOP_LAST) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_next = 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end

      default: begin
        tx_next    = 1'b1;
        done_next  = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
      // NOTE: the shift register is cleared too, so a frame never starts from stale data.
      shift_reg     <= '0;
      tx            <= 1'b1;
      tx_done       <= 1'b1;
      // Resetting to 1 means a request already high at release is not an edge.
      tx_ready_last <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit    <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      baud_cnt      <= baud_next;
      bit_cnt       <= bit_next;
      stop_cnt      <= stop_next;
      shift_reg     <= shift_next;
      tx            <= tx_next;
      tx_done       <= done_next;
      tx_ready_last <= tx_ready;
`ifdef UART_TX_PARITY_EN
      parity_bit    <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: one instance with 1 stop bit,
// one with 2 stop bits for the string-sequencer scenario.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clock;
  logic       reset;
  logic [7:0] tx_data1, tx_data2;
  logic       tx_ready1, tx_ready2;
  logic       tx_done1, tx_done2;
  logic       tx1, tx2;

  int n_cmp = 0;
  int n_mis = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut1 (
    .clock(clock), .reset(reset), .tx_data(tx_data1), .tx_ready(tx_ready1),
    .tx_done(tx_done1), .tx(tx1)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
    .clock(clock), .reset(reset), .tx_data(tx_data2), .tx_ready(tx_ready2),
    .tx_done(tx_done2), .tx(tx2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int frame_cycles(input int stops);
    return (1 + 8 + P + stops) * CPB;
  endfunction

  // Expected line and tx_done per cycle for one frame starting at cycle 'at'.
  task automatic model_frame(inout logic [255:0] etx, inout logic [255:0] edone,
                             input int at, input logic [7:0] d, input int stops);
    logic [11:0] bits;
    int nb;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    nb = 9;
`ifdef UART_TX_PARITY_EN
    bits[9] = ^d;
    nb = 10;
`endif
    nb = nb + stops;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < CPB; c++) begin
        etx[at + b*CPB + c]   = bits[b];
        edone[at + b*CPB + c] = 1'b0;
      end
  endtask

  // Records one sample per cycle (on the falling edge) starting after the next rising edge.
  task automatic capture(input bit sel, input int len,
                         output logic [255:0] obs_tx, output logic [255:0] obs_done);
    obs_tx   = '1;
    obs_done = '1;
    @(posedge clock);
    for (int k = 0; k < len; k++) begin
      @(negedge clock);
      obs_tx[k]   = sel ? tx2 : tx1;
      obs_done[k] = sel ? tx_done2 : tx_done1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tx_ready1 = 1'b1;
    tx_ready2 = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({tx1, tx_done1, tx2, tx_done2} !== 4'b1111) begin
      n_mis++;
      $display("FAIL reset_hold: got tx/done %b want 1111", {tx1, tx_done1, tx2, tx_done2});
    end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      n_cmp++;
      if ({tx1, tx_done1, tx2, tx_done2} !== 4'b1111) begin
        n_mis++;
        $display("FAIL reset_idle cycle %0d: got tx/done %b want 1111", k,
                 {tx1, tx_done1, tx2, tx_done2});
      end
    end
    @(posedge clock); #1;
    tx_ready1 = 1'b0;
    tx_ready2 = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_frames;
    logic [7:0] pats [3] = '{8'h55, 8'h07, 8'h80};
    logic [255:0] obs_tx, obs_done, exp_tx, exp_done;
    int len;
    len = frame_cycles(1) + 3;
    foreach (pats[i]) begin
      exp_tx = '1;
      exp_done = '1;
      model_frame(exp_tx, exp_done, 0, pats[i], 1);
      @(posedge clock); #1;
      tx_data1 = pats[i];
      tx_ready1 = 1'b1;
      fork
        capture(1'b0, len, obs_tx, obs_done);
        begin @(posedge clock); #1; tx_ready1 = 1'b0; end
      join
      for (int k = 0; k < len; k++) begin
        n_cmp++;
        if (obs_tx[k] !== exp_tx[k]) begin
          n_mis++;
          $display("FAIL frame_%h tx cycle %0d: got %b want %b", pats[i], k, obs_tx[k], exp_tx[k]);
        end
        n_cmp++;
        if (obs_done[k] !== exp_done[k]) begin
          n_mis++;
          $display("FAIL frame_%h done cycle %0d: got %b want %b", pats[i], k, obs_done[k], exp_done[k]);
        end
      end
    end
  endtask

  task automatic test_ignore_mid_frame;
    logic [255:0] obs_tx, obs_done, exp_tx, exp_done;
    int len;
    len = frame_cycles(1) + 12;
    exp_tx = '1;
    exp_done = '1;
    model_frame(exp_tx, exp_done, 0, 8'h3C, 1);
    @(posedge clock); #1;
    tx_data1 = 8'h3C;
    tx_ready1 = 1'b1;
    fork
      capture(1'b0, len, obs_tx, obs_done);
      begin
        @(posedge clock); #1;
        tx_ready1 = 1'b0;
        repeat (10) @(posedge clock); #1;
        tx_data1 = 8'hFF;
        tx_ready1 = 1'b1;
        repeat (3) @(posedge clock); #1;
        tx_ready1 = 1'b0;
      end
    join
    for (int k = 0; k < len; k++) begin
      n_cmp++;
      if (obs_tx[k] !== exp_tx[k]) begin
        n_mis++;
        $display("FAIL ignore_mid tx cycle %0d: got %b want %b", k, obs_tx[k], exp_tx[k]);
      end
      n_cmp++;
      if (obs_done[k] !== exp_done[k]) begin
        n_mis++;
        $display("FAIL ignore_mid done cycle %0d: got %b want %b", k, obs_done[k], exp_done[k]);
      end
    end
  endtask

  // Request edge lands on the very cycle tx_done rises, then stays high.
  task automatic test_edge_at_done;
    logic [255:0] obs_tx, obs_done, exp_tx, exp_done;
    int nc, len;
    nc = frame_cycles(1);
    len = nc + 13;
    exp_tx = '1;
    exp_done = '1;
    model_frame(exp_tx, exp_done, 0, 8'hC3, 1);
    @(posedge clock); #1;
    tx_data1 = 8'hC3;
    tx_ready1 = 1'b1;
    fork
      capture(1'b0, len, obs_tx, obs_done);
      begin
        @(posedge clock); #1;
        tx_ready1 = 1'b0;
        repeat (nc - 1) @(posedge clock); #1;
        tx_ready1 = 1'b1;
      end
    join
    for (int k = 0; k < len; k++) begin
      n_cmp++;
      if (obs_tx[k] !== exp_tx[k]) begin
        n_mis++;
        $display("FAIL edge_at_done tx cycle %0d: got %b want %b", k, obs_tx[k], exp_tx[k]);
      end
      n_cmp++;
      if (obs_done[k] !== exp_done[k]) begin
        n_mis++;
        $display("FAIL edge_at_done done cycle %0d: got %b want %b", k, obs_done[k], exp_done[k]);
      end
    end
    tx_ready1 = 1'b0;
    @(posedge clock); #1;
  endtask

  // Reset lands during data bit 3 (bit period 4), then a clean frame follows.
  task automatic test_reset_mid_frame;
    logic [255:0] obs_tx, obs_done, exp_tx, exp_done;
    int len;
    len = 20;
    exp_tx = '1;
    exp_done = '1;
    model_frame(exp_tx, exp_done, 0, 8'hA5, 1);
    for (int k = 18; k < 256; k++) begin
      exp_tx[k] = 1'b1;
      exp_done[k] = 1'b1;
    end
    @(posedge clock); #1;
    tx_data1 = 8'hA5;
    tx_ready1 = 1'b1;
    fork
      capture(1'b0, len, obs_tx, obs_done);
      begin
        @(posedge clock); #1;
        tx_ready1 = 1'b0;
        repeat (17) @(posedge clock); #1;
        reset = 1'b1;
      end
    join
    for (int k = 0; k < len; k++) begin
      n_cmp++;
      if (obs_tx[k] !== exp_tx[k]) begin
        n_mis++;
        $display("FAIL reset_mid tx cycle %0d: got %b want %b", k, obs_tx[k], exp_tx[k]);
      end
      n_cmp++;
      if (obs_done[k] !== exp_done[k]) begin
        n_mis++;
        $display("FAIL reset_mid done cycle %0d: got %b want %b", k, obs_done[k], exp_done[k]);
      end
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock); #1;

    len = frame_cycles(1) + 3;
    exp_tx = '1;
    exp_done = '1;
    model_frame(exp_tx, exp_done, 0, 8'hA5, 1);
    tx_ready1 = 1'b1;
    fork
      capture(1'b0, len, obs_tx, obs_done);
      begin @(posedge clock); #1; tx_ready1 = 1'b0; end
    join
    for (int k = 0; k < len; k++) begin
      n_cmp++;
      if (obs_tx[k] !== exp_tx[k]) begin
        n_mis++;
        $display("FAIL after_reset tx cycle %0d: got %b want %b", k, obs_tx[k], exp_tx[k]);
      end
      n_cmp++;
      if (obs_done[k] !== exp_done[k]) begin
        n_mis++;
        $display("FAIL after_reset done cycle %0d: got %b want %b", k, obs_done[k], exp_done[k]);
      end
    end
  endtask

  // Upstream sequencer sends "HI": waits for tx_done, drops tx_ready one cycle, re-raises.
  task automatic test_string_hi;
    logic [255:0] obs_tx, obs_done, exp_tx, exp_done;
    int nc, len;
    bit seq_ok;
    nc = frame_cycles(2);
    len = 2*nc + 2 + 6;
    seq_ok = 1'b1;
    exp_tx = '1;
    exp_done = '1;
    model_frame(exp_tx, exp_done, 0, 8'h48, 2);
    model_frame(exp_tx, exp_done, nc + 2, 8'h49, 2);
    @(posedge clock); #1;
    tx_data2 = 8'h48;
    tx_ready2 = 1'b1;
    fork
      capture(1'b1, len, obs_tx, obs_done);
      begin
        for (int f = 0; f < 2; f++) begin
          int guard;
          @(posedge clock);
          guard = 0;
          do begin
            @(posedge clock); #1;
            guard++;
          end while (tx_done2 !== 1'b1 && guard < 200);
          if (guard >= 200) seq_ok = 1'b0;
          tx_ready2 = 1'b0;
          if (f == 0) begin
            tx_data2 = 8'h49;
            @(posedge clock); #1;
            tx_ready2 = 1'b1;
          end
        end
      end
    join
    n_cmp++;
    if (seq_ok !== 1'b1) begin
      n_mis++;
      $display("FAIL string_hi timeout: got tx_done wait expired want tx_done within 200 cycles");
    end
    for (int k = 0; k < len; k++) begin
      n_cmp++;
      if (obs_tx[k] !== exp_tx[k]) begin
        n_mis++;
        $display("FAIL string_hi tx cycle %0d: got %b want %b", k, obs_tx[k], exp_tx[k]);
      end
      n_cmp++;
      if (obs_done[k] !== exp_done[k]) begin
        n_mis++;
        $display("FAIL string_hi done cycle %0d: got %b want %b", k, obs_done[k], exp_done[k]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    tx_data1 = 8'h00;
    tx_data2 = 8'h00;
    tx_ready1 = 1'b0;
    tx_ready2 = 1'b0;
    test_reset;
    test_frames;
    test_ignore_mid_frame;
    test_edge_at_done;
    test_reset_mid_frame;
    test_string_hi;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want completion before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
